// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 8-bit core: opcodes, FSM states and instruction field positions.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_LWD   = 8'd9;
  localparam logic [7:0] OP_LWI   = 8'd10;
  localparam logic [7:0] OP_SWD   = 8'd11;
  localparam logic [7:0] OP_SWI   = 8'd12;

  localparam int OPC_LO = 24;
  localparam int RD_LO  = 16;
  localparam int RS1_LO = 8;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, asynchronous clear.
module cpu_mc_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr1,
  input  logic [IDX_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  // Depth rounded up to the index space so out-of-range indices simply wrap.
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/EXEC/MEM/TRAP sequencer with busy-wait handshakes to instruction and data memory.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [PC_W-1:0]   PC,
  output logic              IMEM_READ,
  input  logic              IMEM_BUSY,
  input  logic [31:0]       INSTRUCTION,
  output logic              DMEM_READ,
  output logic              DMEM_WRITE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_BUSY,
  output logic              TRAP
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t            state, state_nx;
  logic [31:0]       ir;
  logic [7:0]        opc, f_rd, f_rs1, f_rs2;
  logic [IDX_W-1:0]  rd, rs1, rs2;
  logic [DATA_W-1:0] a, b, imm_d, alu_y, rf_wdata;
  logic [PC_W-1:0]   pc_inc, br_tgt;
  logic              legal, alu_wr, take_br, is_mem, is_load, rf_we;
  logic              unused_fields;

  assign opc   = ir[OPC_LO +: 8];
  assign f_rd  = ir[RD_LO  +: 8];
  assign f_rs1 = ir[RS1_LO +: 8];
  assign f_rs2 = ir[RS2_LO +: 8];
  assign rd    = f_rd[IDX_W-1:0];
  assign rs1   = f_rs1[IDX_W-1:0];
  assign rs2   = f_rs2[IDX_W-1:0];
  assign imm_d = DATA_W'(f_rs2);
  assign unused_fields = ^f_rs1;

  cpu_mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(IDX_W)) u_rf (
    .clk    (CLK),
    .rst    (RESET),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (a),
    .rdata2 (b)
  );

  // Branch offset is a signed word count relative to the next sequential instruction.
  assign pc_inc = PC + PC_W'(4);
  assign br_tgt = pc_inc + (PC_W'(signed'(f_rd)) << 2);

  always_comb begin
    alu_y   = '0;
    alu_wr  = 1'b0;
    take_br = 1'b0;
    is_mem  = 1'b0;
    is_load = 1'b0;
    legal   = 1'b1;
    case (opc)
      OP_LOADI: begin alu_y = imm_d;                    alu_wr = 1'b1; end
      OP_MOV:   begin alu_y = b;                        alu_wr = 1'b1; end
      OP_ADD:   begin alu_y = a + b;                    alu_wr = 1'b1; end
      OP_SUB:   begin alu_y = a + (~b + DATA_W'(1));    alu_wr = 1'b1; end
      OP_AND:   begin alu_y = a & b;                    alu_wr = 1'b1; end
      OP_OR:    begin alu_y = a | b;                    alu_wr = 1'b1; end
      OP_J:     take_br = 1'b1;
      OP_BEQ:   take_br = (a == b);
      OP_BNE:   take_br = (a != b);
      OP_LWD, OP_LWI: begin is_mem = 1'b1; is_load = 1'b1; end
      OP_SWD, OP_SWI: is_mem = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rf_we    = 1'b0;
    rf_wdata = alu_y;
    case (state)
      S_FETCH: if (!IMEM_BUSY) state_nx = S_EXEC;
      S_EXEC: begin
        rf_we = alu_wr;
        if (!legal)      state_nx = S_TRAP;
        else if (is_mem) state_nx = S_MEM;
        else             state_nx = S_FETCH;
      end
      S_MEM: begin
        rf_wdata = DMEM_RDATA;
        rf_we    = DMEM_READ && !DMEM_BUSY;
        if (!DMEM_BUSY) state_nx = S_FETCH;
      end
      default: state_nx = S_TRAP;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC         <= '0;
      ir         <= '0;
      DMEM_READ  <= 1'b0;
      DMEM_WRITE <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
    end else begin
      case (state)
        S_FETCH: if (!IMEM_BUSY) ir <= INSTRUCTION;
        S_EXEC: begin
          if (legal && is_mem) begin
            DMEM_READ  <= is_load;
            DMEM_WRITE <= !is_load;
            DMEM_ADDR  <= (opc == OP_LWD || opc == OP_SWD) ? b : imm_d;
            DMEM_WDATA <= a;
          end else if (legal) begin
            PC <= take_br ? br_tgt : pc_inc;
          end
        end
        S_MEM: begin
          if (!DMEM_BUSY) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            PC         <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign IMEM_READ = (state == S_FETCH) && !RESET;
  assign TRAP      = (state == S_TRAP);

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: ISA-level reference model plus directed scenarios and random programs.
module tb_cpu_multicycle;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic        IMEM_BUSY = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        DMEM_READ, DMEM_WRITE;
  logic [7:0]  DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic        DMEM_BUSY = 1'b0;
  logic        TRAP;

  always #5 CLK = ~CLK;

  logic [31:0] imem [256];
  logic [7:0]  dmem [256];

  assign INSTRUCTION = imem[PC[9:2]];
  assign DMEM_RDATA  = dmem[DMEM_ADDR];

  cpu_multicycle #(.DATA_W(8), .NREGS(8), .PC_W(32)) u_dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_READ(IMEM_READ), .IMEM_BUSY(IMEM_BUSY),
    .INSTRUCTION(INSTRUCTION), .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_BUSY(DMEM_BUSY), .TRAP(TRAP)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: imem_rand randomises IMEM_BUSY; dmem_k>=0 stalls each data request k cycles, <0 random.
  bit imem_rand = 1'b0;
  int dmem_k = 0;
  int req_cnt = 0;

  always @(posedge CLK) begin
    if (!RESET && DMEM_WRITE && !DMEM_BUSY) dmem[DMEM_ADDR] = DMEM_WDATA;
    #1;
    IMEM_BUSY = imem_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (DMEM_READ || DMEM_WRITE) begin
      DMEM_BUSY = (dmem_k < 0) ? ($urandom_range(0, 2) == 0) : (req_cnt < dmem_k);
      req_cnt++;
    end else begin
      req_cnt = 0;
      DMEM_BUSY = (dmem_k < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Architectural reference model; ph tracks which handshake the core must be performing.
  logic [7:0]  mregs [8];
  logic [7:0]  mmem  [256];
  logic [31:0] mpc;
  int          ph;
  bit          chk_en = 1'b0;
  bit          m_ill, m_mem, m_load;
  logic [7:0]  m_addr, m_wdata;
  int          m_rd;
  int          wr_cnt, rd_cnt;

  task automatic model_exec(input logic [31:0] ins);
    logic [7:0]  op, imm, va, vb;
    int          rdi, so;
    logic [31:0] npc;
    op  = ins[31:24];
    rdi = int'(ins[18:16]);
    va  = mregs[ins[10:8]];
    vb  = mregs[ins[2:0]];
    imm = ins[7:0];
    so  = int'($signed(ins[23:16]));
    npc = mpc + 32'd4;
    m_ill = 1'b0;
    m_mem = 1'b0;
    case (op)
      8'd0:  mregs[rdi] = imm;
      8'd1:  mregs[rdi] = vb;
      8'd2:  mregs[rdi] = 8'((int'(va) + int'(vb)) % 256);
      8'd3:  mregs[rdi] = 8'((int'(va) - int'(vb) + 256) % 256);
      8'd4:  mregs[rdi] = va & vb;
      8'd5:  mregs[rdi] = va | vb;
      8'd6:  npc = mpc + 32'd4 + 32'(so * 4);
      8'd7:  if (va == vb) npc = mpc + 32'd4 + 32'(so * 4);
      8'd8:  if (va != vb) npc = mpc + 32'd4 + 32'(so * 4);
      8'd9:  begin m_mem = 1; m_load = 1; m_addr = vb;  m_rd = rdi; end
      8'd10: begin m_mem = 1; m_load = 1; m_addr = imm; m_rd = rdi; end
      8'd11: begin m_mem = 1; m_load = 0; m_addr = vb;  m_wdata = va; end
      8'd12: begin m_mem = 1; m_load = 0; m_addr = imm; m_wdata = va; end
      default: m_ill = 1'b1;
    endcase
    if (!m_ill && !m_mem) mpc = npc;
  endtask

  always @(negedge CLK) begin
    if (chk_en && !RESET) begin
      chk("imem_read", IMEM_READ, ph == 0);
      chk("dmem_req", DMEM_READ | DMEM_WRITE, ph == 2);
      chk("trap", TRAP, ph == 3);
      chk("rd_wr_excl", DMEM_READ & DMEM_WRITE, 0);
      if (DMEM_WRITE) wr_cnt++;
      if (DMEM_READ)  rd_cnt++;
      case (ph)
        0: if (!IMEM_BUSY) begin
             chk("fetch_pc", PC, mpc);
             model_exec(imem[mpc[9:2]]);
             ph = 1;
           end
        1: ph = m_ill ? 3 : (m_mem ? 2 : 0);
        2: begin
             chk("dmem_read_type", DMEM_READ, m_load);
             chk("dmem_addr", DMEM_ADDR, m_addr);
             if (!m_load) chk("dmem_wdata", DMEM_WDATA, m_wdata);
             if (!DMEM_BUSY) begin
               if (m_load) mregs[m_rd] = mmem[m_addr];
               else        mmem[m_addr] = m_wdata;
               mpc = mpc + 32'd4;
               ph = 0;
             end
           end
        default: chk("trap_pc", PC, mpc);
      endcase
    end
  end

  task automatic begin_reset();
    @(posedge CLK);
    RESET  = 1'b1;
    chk_en = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
  endtask

  task automatic end_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    for (int i = 0; i < 256; i++) mmem[i] = dmem[i];
    mpc = 32'h0;
    ph = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    RESET = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    clear_imem();

    // Reset values and LOADI/LOADI/SUB timing.
    begin_reset();
    chk("rst_pc", PC, 0);
    chk("rst_imem_read", IMEM_READ, 0);
    chk("rst_dmem_read", DMEM_READ, 0);
    chk("rst_trap", TRAP, 0);
    imem[0] = 32'h0001_0005;
    imem[1] = 32'h0002_0003;
    imem[2] = 32'h0303_0102;
    end_reset();
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("t1_pc", PC, 12);
    chk("t1_r3", u_dut.u_rf.regs[3], 8'h02);
    chk("t1_model_r3", mregs[3], 8'h02);

    // Taken BEQ back to 0, then not-taken BNE falls through to 8.
    begin_reset();
    clear_imem();
    imem[0] = 32'h0001_0001;
    imem[1] = 32'h07FE_0101;
    end_reset();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("t2_beq_pc", PC, 0);
    begin_reset();
    imem[1] = 32'h08FE_0101;
    end_reset();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("t2_bne_pc", PC, 8);

    // SWI with 3 stall cycles.
    begin_reset();
    clear_imem();
    imem[0] = 32'h0001_00AA;
    imem[1] = 32'h0C00_0140;
    dmem_k = 3;
    end_reset();
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk("t3_write_cycles", wr_cnt, 4);
    chk("t3_mem40", dmem[8'h40], 8'hAA);

    // LWD with 2 stall cycles.
    begin_reset();
    clear_imem();
    imem[0] = 32'h0002_0033;
    imem[1] = 32'h0904_0002;
    dmem[8'h33] = 8'h7F;
    dmem_k = 2;
    end_reset();
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk("t4_read_cycles", rd_cnt, 3);
    chk("t4_r4", u_dut.u_rf.regs[4], 8'h7F);
    chk("t4_model_r4", mregs[4], 8'h7F);

    // Illegal opcode at PC=8 traps; reset clears it.
    begin_reset();
    clear_imem();
    imem[2] = 32'hFF00_0000;
    dmem_k = 0;
    end_reset();
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("t5_trap", TRAP, 1);
    chk("t5_pc", PC, 8);
    chk("t5_no_fetch", IMEM_READ, 0);
    begin_reset();
    end_reset();
    #1;
    chk("t5_trap_cleared", TRAP, 0);
    chk("t5_pc_cleared", PC, 0);
    chk("t5_fetch_again", IMEM_READ, 1);

    // Reset in the middle of a stalled load, then 0xFF + 0x01 wraps to 0.
    begin_reset();
    clear_imem();
    imem[0] = 32'h0001_0009;
    imem[1] = 32'h0A05_0010;
    dmem_k = 100;
    end_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = DMEM_READ;
    end
    chk("t6_req_seen", seen, 1);
    repeat (2) @(negedge CLK);
    #2;
    chk_en = 1'b0;
    RESET = 1'b1;
    #1;
    chk("t6_read_dropped", DMEM_READ, 0);
    chk("t6_no_fetch", IMEM_READ, 0);
    chk("t6_r1_cleared", u_dut.u_rf.regs[1], 8'h00);
    dmem_k = 0;
    begin_reset();
    clear_imem();
    imem[0] = 32'h0001_00FF;
    imem[1] = 32'h0002_0001;
    imem[2] = 32'h0203_0102;
    imem[3] = 32'h0C00_0320;
    dmem[8'h20] = 8'h55;
    end_reset();
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    chk("t6_add_wrap", dmem[8'h20], 8'h00);
    chk("t6_model_r3", mregs[3], 8'h00);

    // Random programs, random operands and random stalls against the model.
    imem_rand = 1'b1;
    dmem_k = -1;
    for (int r = 0; r < 6; r++) begin
      begin_reset();
      for (int i = 0; i < 256; i++) begin
        logic [7:0] op;
        op = ($urandom_range(0, 399) == 0) ? 8'(13 + $urandom_range(0, 242)) : 8'($urandom_range(0, 12));
        imem[i] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
        dmem[i] = 8'($urandom);
      end
      end_reset();
      repeat (1500) @(posedge CLK);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(posedge CLK);
        #2;
        seen = (ph == 0) || (ph == 3);
      end
      chk("rand_quiesce", seen, 1);
      if (seen) begin
        for (int i = 0; i < 8; i++) chk("rand_reg", u_dut.u_rf.regs[i], mregs[i]);
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
